spi_master_gen: RTL and testbench

Parametrised SPI master: the next generation of the team's 8-bit mode-0 SPI controller, used by the NIOS-side peripherals (SD card, sensors, flash). It adds configurable word width, all four SPI modes (CPOL/CPHA) selected per transfer, MSB- or LSB-first shifting, a 16-bit clock divider, and up to 2**CS_W active-low chip selects. Chip select can be held across back-to-back words for multi-byte commands. It sits between a register-mapped CPU wrapper and the board SPI pins.

---
 rtl/spi_master_gen.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI master.
// Supports a configurable word width, all four CPOL/CPHA modes selected per
// transfer, MSB- or LSB-first shifting, a programmable SCLK divider and
// 2**CS_W active-low chip selects. A select line can stay asserted across
// words so that multi-byte commands are possible.
module spi_master_gen #(
  parameter int DATA_W    = 8,
  parameter int DVSR_W    = 16,
  parameter int CS_W      = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    din,
  input  logic [DVSR_W-1:0]    dvsr,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [CS_W-1:0]      cs_sel,
  input  logic                 cs_hold,
  input  logic                 start,
  output logic [DATA_W-1:0]    dout,
  output logic                 busy,
  output logic                 done_tick,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [2**CS_W-1:0]   spi_cs_n
);

  localparam int NCS   = 2**CS_W;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, HALF0, HALF1, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DVSR_W-1:0]   cnt_q, cnt_d, dvsr_q, dvsr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, dout_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, hold_q, hold_d;
  logic [CS_W-1:0]     sel_q, sel_d;
  logic                busy_d, done_d, clk_d, mosi_d;
  logic [NCS-1:0]      cs_n_d;
  logic                last;

  // Bit that goes on the wire first for a given shift-register value.
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  // Drop the bit just sent so the next one moves to the output end.
  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  assign last = (cnt_q == dvsr_q);

  // Next-state and next-output logic; every state lasts dvsr+1 cycles.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves a value unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dvsr_d  = dvsr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    busy_d  = busy;
    done_d  = 1'b0;
    clk_d   = spi_clk;
    mosi_d  = spi_mosi;
    cs_n_d  = spi_cs_n;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          dvsr_d  = dvsr;
          cpol_d  = cpol;
          cpha_d  = cpha;
          hold_d  = cs_hold;
          sel_d   = cs_sel;
          tx_d    = din;
          bit_d   = '0;
          busy_d  = 1'b1;
          clk_d   = cpol;
          mosi_d  = first_bit(din);
          // A line still held from an earlier word is released here if
          // the new word addresses a different slave.
          cs_n_d         = '1;
          cs_n_d[cs_sel] = 1'b0;
        end
      end
      SETUP: begin
        if (last) begin
          state_d = HALF0;
          cnt_d   = '0;
          clk_d   = cpol_q ^ cpha_q;
        end
      end
      HALF0: begin
        if (last) begin
          state_d = HALF1;
          cnt_d   = '0;
          clk_d   = cpol_q ^ ~cpha_q;
          if (LSB_FIRST != 0) rx_d = {spi_miso, rx_q[DATA_W-1:1]};
          else                rx_d = {rx_q[DATA_W-2:0], spi_miso};
        end
      end
      HALF1: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_W-1)) begin
            state_d = HOLD;
            clk_d   = cpol_q;
          end else begin
            state_d = HALF0;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_tx(tx_q);
            mosi_d  = first_bit(shift_tx(tx_q));
            clk_d   = cpol_q ^ cpha_q;
          end
        end
      end
      HOLD: begin
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          dout_d  = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (!hold_q) cs_n_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvsr_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      hold_q    <= 1'b0;
      sel_q     <= '0;
      dout      <= '0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      dout      <= dout_d;
      busy      <= busy_d;
      done_tick <= done_d;
      spi_clk   <= clk_d;
      spi_mosi  <= mosi_d;
      spi_cs_n  <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Testbench for spi_master_gen: a transfer-level timing model plus an SPI
// slave model, compared against the DUT on every cycle, with directed
// literal checks and randomized transfers.
module tb_spi_master_gen;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = '0;
  logic [15:0] dvsr = '0;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic        cs_hold = 1'b0, start = 1'b0;
  logic [7:0]  dout;
  logic        busy, done_tick, spi_clk, spi_mosi, spi_miso;
  logic [3:0]  spi_cs_n;

  // 16-bit LSB-first instance
  logic [15:0] din16 = '0, dout16;
  logic [15:0] dvsr16 = '0;
  logic        cpol16 = 1'b0, cpha16 = 1'b0, hold16 = 1'b0, start16 = 1'b0;
  logic [1:0]  sel16 = '0;
  logic        busy16, done16, sclk16, mosi16, miso16 = 1'b0;
  logic [3:0]  cs16;

  always #5 clk = ~clk;

  spi_master_gen #(.DATA_W(8), .DVSR_W(16), .CS_W(2), .LSB_FIRST(0)) u_dut (
    .clk(clk), .reset(reset), .din(din), .dvsr(dvsr), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .cs_hold(cs_hold), .start(start), .dout(dout), .busy(busy),
    .done_tick(done_tick), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  spi_master_gen #(.DATA_W(16), .DVSR_W(16), .CS_W(2), .LSB_FIRST(1)) u_dut16 (
    .clk(clk), .reset(reset), .din(din16), .dvsr(dvsr16), .cpol(cpol16), .cpha(cpha16),
    .cs_sel(sel16), .cs_hold(hold16), .start(start16), .dout(dout16), .busy(busy16),
    .done_tick(done16), .spi_clk(sclk16), .spi_mosi(mosi16),
    .spi_miso(miso16), .spi_cs_n(cs16)
  );

  int total = 0, bad = 0;
  int cyc = 0, k_acc = 0, done_cnt = 0, cs2_gaps = 0;
  bit chk_en = 1'b0, mon_cs2 = 1'b0, loopback = 1'b0;
  logic [7:0] reply = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // i-th bit on the wire for the MSB-first instance
  function automatic logic bitof(input logic [7:0] w, input int i);
    return w[D-1-i];
  endfunction

  always @(posedge clk) cyc++;

  // ---------------- transfer-level model ----------------
  bit         m_active = 0, m_done = 0, m_cpol = 0, m_cpha = 0, m_hold = 0, m_idle_mosi = 0;
  int         m_c = 0, m_h = 1, m_len = 0;
  logic [7:0] m_din = '0, m_exp_rx = '0, m_dout = '0;
  logic [3:0] m_cs_n = 4'hF;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_c = 0; m_dout = '0; m_cs_n = 4'hF;
      m_cpol = 0; m_cpha = 0; m_idle_mosi = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        m_c++;
        if (m_c == m_len) begin
          m_active = 0; m_done = 1; m_dout = m_exp_rx;
          m_idle_mosi = bitof(m_din, D-1);
          if (!m_hold) m_cs_n = 4'hF;
        end
      end else if (start) begin
        m_active = 1; m_c = 0;
        m_h = int'(dvsr) + 1;
        m_len = (2*D + 2) * m_h;
        m_cpol = cpol; m_cpha = cpha; m_hold = cs_hold; m_din = din;
        m_cs_n = 4'hF; m_cs_n[cs_sel] = 1'b0;
        m_exp_rx = loopback ? din : reply;
      end
    end
  end

  // ---------------- SPI slave model ----------------
  logic [7:0] s_word = '0, s_rx = '0;
  logic       s_miso = 1'b0, s_prev_clk = 1'b0;
  int         s_idx = 0;

  assign spi_miso = loopback ? spi_mosi : s_miso;

  always @(negedge clk) begin
    if (m_active && m_c == 0) begin
      s_word = reply; s_idx = 0; s_rx = '0;
      if (!m_cpha) s_miso = bitof(s_word, 0);
    end else if (!(&spi_cs_n) && spi_clk != s_prev_clk) begin
      if (spi_clk != m_cpol) begin           // leading edge
        if (!m_cpha) begin
          if (s_idx < D) s_rx[D-1-s_idx] = spi_mosi;
        end else begin
          if (s_idx < D) s_miso = bitof(s_word, s_idx);
        end
      end else begin                         // trailing edge
        if (!m_cpha) begin
          s_idx++;
          if (s_idx < D) s_miso = bitof(s_word, s_idx);
        end else begin
          if (s_idx < D) s_rx[D-1-s_idx] = spi_mosi;
          s_idx++;
        end
      end
    end
    s_prev_clk = spi_clk;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic e_clk, e_mosi;
    int   p;
    if (chk_en) begin
      e_clk  = m_cpol;
      e_mosi = m_idle_mosi;
      if (m_active) begin
        p = m_c / m_h;
        if (p == 0) e_mosi = bitof(m_din, 0);
        else if (p <= 2*D) begin
          e_mosi = bitof(m_din, (p-1)/2);
          e_clk  = m_cpol ^ (m_cpha ? ((p-1)%2 == 0) : ((p-1)%2 == 1));
        end else e_mosi = bitof(m_din, D-1);
      end
      check("busy", busy, m_active);
      check("done_tick", done_tick, m_done);
      check("dout", dout, m_dout);
      check("spi_cs_n", spi_cs_n, m_cs_n);
      check("spi_clk", spi_clk, e_clk);
      check("spi_mosi", spi_mosi, e_mosi);
      if (m_done) check("slave_rx", s_rx, m_din);
    end
  end

  always @(negedge clk) if (done_tick) done_cnt++;
  always @(negedge clk) if (mon_cs2 && spi_cs_n[2]) cs2_gaps++;

  // ---------------- 16-bit LSB-first slave (mode 0) ----------------
  logic [15:0] reply16 = '0, rx16 = '0;
  logic        prev_cs16 = 1'b1, prev_clk16 = 1'b0;
  int          idx16 = 0;

  always @(negedge clk) begin
    if (prev_cs16 && !cs16[0]) begin
      idx16 = 0; miso16 = reply16[0];
    end else if (!cs16[0] && sclk16 && !prev_clk16) begin
      if (idx16 < 16) rx16[idx16] = mosi16;
    end else if (!cs16[0] && !sclk16 && prev_clk16) begin
      idx16++;
      if (idx16 < 16) miso16 = reply16[idx16];
    end
    prev_cs16 = cs16[0];
    prev_clk16 = sclk16;
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge of the first SETUP cycle.
  task automatic go(input logic [7:0] d, input int dv, input logic pol, input logic pha,
                    input logic [1:0] sel, input logic hold, input logic [7:0] rep);
    din = d; dvsr = 16'(dv); cpol = pol; cpha = pha;
    cs_sel = sel; cs_hold = hold; reply = rep; start = 1'b1;
    k_acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_tick && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_tick, 1);
  endtask

  initial begin
    int d0;
    int n16;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done_tick, 0);
    check("rst_dout", dout, 0);
    check("rst_cs_n", spi_cs_n, 4'hF);
    check("rst_clk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset during HALF1 of bit 3 (H=2: relative cycles 16..17)
    go(8'h96, 1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h55);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", spi_cs_n, 4'hF);
    check("abort_clk", spi_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt, 0);

    // Mode 0 loopback, dvsr=0
    loopback = 1'b1;
    go(8'hA5, 0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    wait_done(100);
    check("loop_dout", dout, 8'hA5);
    check("loop_mosi_serial", s_rx, 8'hA5);
    check("loop_latency", cyc - k_acc, 18);
    check("loop_cs_idle", spi_cs_n, 4'hF);
    loopback = 1'b0;
    @(negedge clk);

    // All four modes, dvsr=3, slave returns 0x3C
    for (int m = 0; m < 4; m++) begin
      go(8'($urandom), 3, 1'(m >> 1), 1'(m), 2'd0, 1'b0, 8'h3C);
      wait_done(200);
      check("mode_dout", dout, 8'h3C);
      check("mode_latency", cyc - k_acc, 72);
      repeat (2) @(negedge clk);
    end

    // start pulsed mid-transfer is ignored
    go(8'h5A, 1, 1'b0, 1'b1, 2'd1, 1'b0, 8'hC3);
    repeat (5) @(negedge clk);
    din = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    wait_done(100);
    check("mid_start_dout", dout, 8'hC3);
    repeat (12) @(negedge clk);
    check("mid_start_dones", done_cnt - d0, 1);
    check("mid_start_idle", busy, 0);

    // Held chip select across back-to-back words on line 2
    go(8'h11, 0, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA1);
    mon_cs2 = 1'b1;
    wait_done(100);
    go(8'h22, 0, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA2);
    wait_done(100);
    go(8'h33, 0, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA3);
    wait_done(100);
    go(8'h44, 0, 1'b0, 1'b0, 2'd2, 1'b0, 8'hA4);
    mon_cs2 = 1'b0;
    wait_done(100);
    check("hold_cs2_gaps", cs2_gaps, 0);
    check("hold_release", spi_cs_n, 4'hF);
    check("hold_last_dout", dout, 8'hA4);
    @(negedge clk);

    // Held line 1, then switch to line 3
    go(8'h0F, 0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h5C);
    wait_done(100);
    check("held_idle_cs", spi_cs_n, 4'b1101);
    @(negedge clk);
    check("held_idle_cs2", spi_cs_n, 4'b1101);
    go(8'hF0, 0, 1'b0, 1'b0, 2'd3, 1'b0, 8'h6D);
    check("switch_cs", spi_cs_n, 4'b0111);
    wait_done(100);
    check("switch_release", spi_cs_n, 4'hF);

    // Randomized transfers, including back-to-back and held words
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      go(8'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
         2'($urandom), 1'($urandom), 8'($urandom));
      wait_done(200);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // 16-bit LSB-first instance
    din16 = 16'h0001; reply16 = 16'h8000; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("lsb16_first_bit", mosi16, 1);
    n16 = 0;
    while (!done16 && n16 < 100) begin
      @(negedge clk);
      n16++;
    end
    check("lsb16_done_seen", done16, 1);
    check("lsb16_dout", dout16, 16'h8000);
    check("lsb16_mosi_serial", rx16, 16'h0001);
    check("lsb16_cs_idle", cs16, 4'hF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
